// File: rtl/uart_pkg.sv
// Shared UART constants, state encoding and baud helper, common to the
// transmitter and the receiver so both sides agree on framing and timing.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } UartState;

    // Integer truncation matches the receiver's bit timing exactly.
    function automatic int calcClksPerBit(input int sysClk, input int baudRate);
        return sysClk / baudRate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: free-running 0..CLKS_PER_BIT-1 counter with a synchronous
// clear, producing a one-cycle bit_end tick on the last count of each period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] baudCount_q;
    logic [CNT_W-1:0] baudCount_d;

    always_comb begin
        baudCount_d = baudCount_q;
        if (clear || (baudCount_q == LAST_COUNT)) begin
            baudCount_d = '0;
        end else begin
            baudCount_d = baudCount_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baudCount_q <= '0;
        end else begin
            baudCount_q <= baudCount_d;
        end
    end

    assign bit_end = (baudCount_q == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per request, LSB first, 8N1 framing on a registered line.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int SYS_CLK   = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_tx_d,
    output logic                 o_tx_d,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);

    localparam int CLKS_PER_BIT = calcClksPerBit(SYS_CLK, BAUD_RATE);
    localparam int BIT_CNT_W    = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    UartState                 state_q;
    UartState                 state_d;
    logic [DATA_BITS-1:0]     shift_q;
    logic [DATA_BITS-1:0]     shift_d;
    logic [BIT_CNT_W-1:0]     bitCount_q;
    logic [BIT_CNT_W-1:0]     bitCount_d;
    logic                     txLine_q;
    logic                     txLine_d;
    logic                     busy_q;
    logic                     busy_d;
    logic                     done_q;
    logic                     done_d;
`ifdef UART_TX_PARITY_EN
    logic                     parity_q;
    logic                     parity_d;
`endif

    logic bitEnd;
    logic baudClear;

    // Holding the timer cleared while idle restarts every frame on a clean period.
    assign baudClear = (state_q == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) baudGen (
        .clk    (clk),
        .rst    (rst),
        .clear  (baudClear),
        .bit_end(bitEnd)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitCount_d = bitCount_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_tx_start) begin
                    shift_d    = i_tx_d;
                    bitCount_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^i_tx_d;
`endif
                    state_d    = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shift_d    = shift_q >> 1;
                    bitCount_d = bitCount_q + BIT_CNT_W'(1);
                    if (bitCount_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bitEnd) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered line
        // changes on the same edge as the state itself.
        txLine_d = 1'b1;
        case (state_d)
            START:   txLine_d = 1'b0;
            DATA:    txLine_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txLine_d = parity_q;
`endif
            default: txLine_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && bitEnd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bitCount_q <= '0;
            txLine_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitCount_q <= bitCount_d;
            txLine_q   <= txLine_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign o_tx_d    = txLine_q;
    assign o_tx_busy = busy_q;
    assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level reference model predicts the
// line/busy/done every cycle, and a bench UART receiver decodes the line.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int SYS_CLK   = 50_000_000;
    localparam int BAUD_RATE = 115_200;
    localparam int CPB       = SYS_CLK / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_tx_start = 1'b0;
    logic [7:0] i_tx_d = 8'h00;
    logic       o_tx_d;
    logic       o_tx_busy;
    logic       o_tx_done;

    always #5 clk = ~clk;

    uart_tx #(
        .SYS_CLK  (SYS_CLK),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_tx_start(i_tx_start),
        .i_tx_d    (i_tx_d),
        .o_tx_d    (o_tx_d),
        .o_tx_busy (o_tx_busy),
        .o_tx_done (o_tx_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, observed, expected);
        end
    endtask

    // Reference model: each accepted byte becomes a list of frame bits, each
    // held for CPB cycles; the line simply replays that list.
    bit                  modelLine = 1'b1;
    bit                  modelBusy = 1'b0;
    bit                  modelDone = 1'b0;
    bit                  frameQ[$];
    logic [7:0]          sentQ[$];
    logic [FRAME_BITS-1:0] frameBits;
    int                  cyc = 0;
    int                  acceptEdge = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            if (modelBusy) void'(sentQ.pop_back());
            frameQ.delete();
            modelLine = 1'b1;
            modelBusy = 1'b0;
            modelDone = 1'b0;
        end else begin
            if (!modelBusy && i_tx_start) begin
                frameBits = '1;
                frameBits[0] = 1'b0;
                frameBits[8:1] = i_tx_d;
`ifdef UART_TX_PARITY_EN
                frameBits[9] = ^i_tx_d;
`endif
                for (int b = 0; b < FRAME_BITS; b++)
                    for (int c = 0; c < CPB; c++)
                        frameQ.push_back(frameBits[b]);
                sentQ.push_back(i_tx_d);
                acceptEdge = cyc;
            end
            if (frameQ.size() > 0) begin
                modelLine = frameQ.pop_front();
                modelDone = 1'b0;
                modelBusy = 1'b1;
            end else begin
                modelLine = 1'b1;
                modelDone = modelBusy;
                modelBusy = 1'b0;
            end
        end
    end

    // Per-cycle comparison plus a bench receiver sampling mid-bit.
    int         rxActive = 0;
    int         rxT = 0;
    int         rxJ = 0;
    logic [7:0] rxByte = 8'h00;
    logic [7:0] rxQ[$];
    logic       prevLine = 1'b1;

    always @(negedge clk) begin
        if (cyc > 0) begin
            checkOutput("lineBusyDone", {o_tx_d, o_tx_busy, o_tx_done}, {modelLine, modelBusy, modelDone});
            if (o_tx_done) checkOutput("doneLatency", cyc - acceptEdge, FRAME);
        end
        if (rst) begin
            rxActive = 0;
        end else if (rxActive == 0) begin
            if (prevLine && !o_tx_d) begin
                rxActive = 1;
                rxT = 0;
            end
        end else begin
            rxT++;
        end
        if (rxActive != 0 && (rxT % CPB) == CPB / 2) begin
            rxJ = rxT / CPB;
            if (rxJ == 0) begin
                if (o_tx_d) rxActive = 0;
            end else if (rxJ <= 8) begin
                rxByte[rxJ-1] = o_tx_d;
            end else if (rxJ == FRAME_BITS - 1) begin
                checkOutput("rxStopBit", o_tx_d, 1'b1);
                rxQ.push_back(rxByte);
                rxActive = 0;
            end else begin
                checkOutput("rxParity", o_tx_d, ^rxByte);
            end
        end
        prevLine = o_tx_d;
    end

    task automatic applyStimulus(input logic [7:0] data);
        @(negedge clk);
        #1;
        i_tx_start = 1'b1;
        i_tx_d     = data;
        @(negedge clk);
        #1;
        i_tx_start = 1'b0;
        i_tx_d     = 8'($urandom);
    endtask

    task automatic waitDone(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < FRAME + CPB && !seen; n++) begin
            @(negedge clk);
            if (o_tx_done) seen = 1'b1;
        end
        checkOutput(tag, seen, 1'b1);
    endtask

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (1000) @(negedge clk);

        $display("[TB] single frame 0x55");
        applyStimulus(8'h55);
        waitDone("done_0x55");

        $display("[TB] back-to-back 0xA3 then 0x0F");
        applyStimulus(8'hA3);
        waitDone("done_0xA3");
        #1;
        i_tx_start = 1'b1;
        i_tx_d     = 8'h0F;
        @(negedge clk);
        #1 i_tx_start = 1'b0;
        checkOutput("b2bStartBit", o_tx_d, 1'b0);
        waitDone("done_0x0F");

        $display("[TB] request while busy is ignored");
        applyStimulus(8'h00);
        repeat (3 * CPB) @(negedge clk);
        #1;
        i_tx_start = 1'b1;
        i_tx_d     = 8'hFF;
        @(negedge clk);
        #1 i_tx_start = 1'b0;
        waitDone("done_0x00");

        $display("[TB] reset in the middle of bit 4");
        applyStimulus(8'h3C);
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("rstLine", o_tx_d, 1'b1);
        checkOutput("rstBusy", o_tx_busy, 1'b0);
        #1;
        i_tx_start = 1'b1;
        i_tx_d     = 8'h5A;
        @(negedge clk);
        checkOutput("rstWinsLine", o_tx_d, 1'b1);
        #1;
        rst        = 1'b0;
        i_tx_start = 1'b0;
        repeat (5) @(negedge clk);
        applyStimulus(8'h81);
        waitDone("done_0x81");

`ifdef UART_TX_PARITY_EN
        $display("[TB] parity frames");
        applyStimulus(8'h07);
        waitDone("done_0x07");
        applyStimulus(8'h03);
        waitDone("done_0x03");
`endif

        $display("[TB] randomized frames");
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            applyStimulus(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, FRAME - 2 * CPB)) @(negedge clk);
                #1;
                i_tx_start = 1'b1;
                i_tx_d     = 8'($urandom);
                @(negedge clk);
                #1 i_tx_start = 1'b0;
            end
            waitDone("done_random");
        end

        repeat (10) @(negedge clk);
        checkOutput("rxCount", rxQ.size(), sentQ.size());
        for (int i = 0; i < rxQ.size() && i < sentQ.size(); i++)
            checkOutput("rxByte", rxQ[i], sentQ[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises one byte per request into a standard 8N1 frame (optionally 8E1) on a single output line at a fixed baud rate. It is the transmit-side companion of the team's UART receiver: same system clock, same baud constants, same LSB-first bit order. It sits between a byte-producing client, such as a command/response controller, and the board TX pin.

## Interface
- SYS_CLK, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- CLKS_PER_BIT, SYS_CLK/BAUD_RATE (integer truncation, 434 at defaults), clocks per bit period. This is a derived localparam, not overridable.

- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_tx_start  input  1  transmit request; sampled only in IDLE.
- i_tx_d  input  8  byte to send; captured on the accepting edge.
- o_tx_d  output  1  serial line; idles high.
- o_tx_busy  output  1  high from the accept cycle+1 through the end of the stop bit.
- o_tx_done  output  1  one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - o_tx_d=1, o_tx_busy=0.
  - If i_tx_start=1, latch i_tx_d into the shift register, clear the bit counter (3 bits) and the baud counter, then go to START.
- START: o_tx_d=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - o_tx_d = shift_reg[0].
  - At each bit-period end, shift right and increment the bit counter.
  - After bit 7 (counter == 7 at period end), go to PARITY or STOP.
- PARITY: o_tx_d = even-parity bit (XOR of the latched byte) for one period, then go to STOP.
- STOP:
  - o_tx_d=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - Assert o_tx_done for exactly the first IDLE cycle.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - The bit-period end is count == CLKS_PER_BIT-1.
  - Reset to 0 on every state entry from IDLE.
- i_tx_start while busy is ignored; no queuing.
- i_tx_d changes after acceptance do not affect the frame in flight.
- o_tx_d is driven from a register, so the line is glitch-free.

## Timing
- Reset values: o_tx_d=1, o_tx_busy=0, o_tx_done=0, state=IDLE, all counters 0.
- Accept edge N, where i_tx_start=1 in IDLE:
  - o_tx_d=0 and o_tx_busy=1 from cycle N+1.
  - The start bit occupies cycles N+1..N+CLKS_PER_BIT.
- Data bit k occupies cycles N+1+(k+1)·CLKS_PER_BIT onward, for CLKS_PER_BIT cycles.
- Frame length is 10·CLKS_PER_BIT cycles (4340 at defaults), or 11·CLKS_PER_BIT with parity.
- o_tx_done=1 and o_tx_busy=0 in cycle N+1+10·CLKS_PER_BIT (11· with parity).
- Back-to-back frames: i_tx_start held high in the o_tx_done cycle is accepted in that cycle. The next start bit follows with zero idle gap beyond the full stop bit.
- Reset asserted mid-frame: on the next edge, all outputs return to their reset values. The line goes high immediately and the partial frame is abandoned; no o_tx_done pulse.
- Simultaneous rst and i_tx_start: reset wins and the request is dropped.

## Configuration
- UART_TX_PARITY_EN defined:
  - The PARITY state is compiled in.
  - Frame is start + 8 data + even parity + stop.
  - o_tx_done timing shifts by one bit period.
- Undefined: PARITY logic is absent and the frame is 8N1.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS=8;
  - a function computing CLKS_PER_BIT from SYS_CLK/BAUD_RATE.
  - It is reused by the receiver for matching constants.
- Sub-module uart_baud_gen:
  - Inputs: clk, rst, clear.
  - Output: a one-cycle bit_end tick at count == CLKS_PER_BIT-1.
  - The FSM, shift register and bit counter stay in uart_tx.

## Test plan
- Reset release, no request for 1000 cycles -> o_tx_d=1, o_tx_busy=0, o_tx_done=0 throughout.
- Send 0x55 at defaults -> line sequence 0,1,0,1,0,1,0,1,0,1, each 434 cycles. o_tx_done pulses exactly 4340 cycles after the cycle following accept.
- Send 0xA3, then reassert i_tx_start in the o_tx_done cycle with 0x0F -> the second start bit begins the next cycle. A bench UART receiver model decodes 0xA3 then 0x0F.
- Pulse i_tx_start with 0xFF during a DATA bit of a 0x00 frame -> ignored. Only 0x00 is decoded and o_tx_done pulses once.
- Assert rst for 1 cycle in the middle of bit 4 of 0x3C -> o_tx_d=1 and o_tx_busy=0 on the next edge, no o_tx_done. A following send of 0x81 decodes correctly.
- With UART_TX_PARITY_EN: send 0x07 -> parity bit 1. Send 0x03 -> parity bit 0. Frame length is 4774 cycles.
